// File: rtl/apb_req_master.sv
// Single-outstanding valid/ready -> APB requester; 4 cycles min per transfer (accept, SETUP, ACCESS, RESP).
// Backpressure: req_ready_o only in IDLE; the response holds until rsp_ready_i; optional ACCESS timeout.
module apb_req_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                    pclk_i,
  input  logic                    preset_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_tout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]              r_state;
  logic                    r_rst_done;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [DATA_WIDTH/8-1:0] r_pstrb;
  logic [2:0]              r_pprot;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic                    r_tout;
  logic [CNT_W-1:0]        r_cnt;

  logic w_accept;
  logic w_tout;

  assign w_accept = (r_state == S_IDLE) && r_rst_done && req_valid_i;
  // The counter holds completed not-ready ACCESS cycles, so this fires on the last allowed one.
  assign w_tout   = (TIMEOUT_CYCLES != 0) && (r_state == S_ACCESS) && !pready_i &&
                    ((int'(r_cnt) + 1) == TIMEOUT_CYCLES);

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_state    <= S_IDLE;
      r_rst_done <= 1'b0;
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
      r_pstrb    <= '0;
      r_pprot    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_tout     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_rst_done <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_paddr  <= req_addr_i;
            r_pwrite <= req_write_i;
            r_pwdata <= req_wdata_i;
            r_pstrb  <= req_write_i ? req_strb_i : '0;
            r_pprot  <= req_prot_i;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt   <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready_i) begin
            r_rdata <= r_pwrite ? '0 : prdata_i;
            r_err   <= pslverr_i;
            r_tout  <= 1'b0;
            r_state <= S_RESP;
          end else if (w_tout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_tout  <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (rsp_ready_i) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = (r_state == S_IDLE) && r_rst_done;
  assign psel_o      = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign penable_o   = (r_state == S_ACCESS);
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign rsp_tout_o  = r_tout;
  assign paddr_o     = r_paddr;
  assign pwrite_o    = r_pwrite;
  assign pwdata_o    = r_pwdata;
  assign pstrb_o     = r_pstrb;
  assign pprot_o     = r_pprot;

  a_access_hold: assert property (@(posedge pclk_i) disable iff (!preset_ni)
    (penable_o && !pready_i && !w_tout) |=>
      (psel_o && penable_o && $stable({paddr_o, pwrite_o, pwdata_o, pstrb_o, pprot_o})));

  a_en_needs_sel: assert property (@(posedge pclk_i) disable iff (!preset_ni)
    penable_o |-> psel_o);

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master against a behavioural read-only register completer
// (base 0x0003_0000, reg[i]=i, 10 regs) with programmable wait states / hang.
module tb_apb_req_master;

  localparam logic [31:0] BASE = 32'h0003_0000;

  logic        pclk_i = 1'b0;
  logic        preset_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        req_write_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_strb_i = '0;
  logic [2:0]  req_prot_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_tout_o;
  logic [31:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  apb_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk_i(pclk_i), .preset_ni(preset_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
    .req_strb_i(req_strb_i), .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_tout_o(rsp_tout_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 pclk_i = ~pclk_i;

  // Completer model
  int          wait_states = 0;
  bit          hang = 1'b0;
  logic [31:0] acc_cnt;
  logic        in_range;

  always @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) acc_cnt <= '0;
    else if (psel_o && penable_o && !pready_i) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= '0;
  end

  always_comb begin
    in_range  = (paddr_o >= BASE) && (paddr_o <= BASE + 32'd36) && (paddr_o[1:0] == 2'b00);
    pready_i  = psel_o && penable_o && !hang && (int'(acc_cnt) >= wait_states);
    prdata_i  = in_range ? ((paddr_o - BASE) >> 2) : 32'd0;
    pslverr_i = psel_o && penable_o && (pwrite_o || !in_range);
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int          setup_cnt = 0;
  int          access_cnt = 0;
  logic [31:0] s_addr;
  logic        s_write;
  logic [3:0]  s_strb;
  logic [31:0] s_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: transfer statistics and response scoreboard
  always @(negedge pclk_i) begin
    if (preset_ni) begin
      if (req_valid_i && req_ready_o) begin
        setup_cnt  = 0;
        access_cnt = 0;
      end
      if (psel_o && !penable_o) begin
        setup_cnt++;
        s_addr  = paddr_o;
        s_write = pwrite_o;
        s_strb  = pstrb_o;
        s_wdata = pwdata_o;
      end
      if (psel_o && penable_o) access_cnt++;
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata=0x%0h err=%0b tout=%0b, none expected",
                   rsp_rdata_o, rsp_err_o, rsp_tout_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp {rdata,err,tout}", {30'd0, rsp_rdata_o, rsp_err_o, rsp_tout_o},
              {30'd0, e.rdata, e.err, e.tout});
        end
      end
    end
  end

  task automatic drive_req(input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    bit ok;
    ok = 1'b0;
    @(posedge pclk_i); #1;
    req_addr_i  = addr;
    req_write_i = wr;
    req_wdata_i = wdata;
    req_strb_i  = strb;
    req_prot_i  = 3'b010;
    req_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk_i);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge pclk_i); #1;
    req_valid_i = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_accept: req_ready_o stayed 0, required 1 within 100 cycles");
    end
  endtask

  task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] erd, input logic eerr,
                        input logic etout);
    exp_t e;
    e.rdata = erd;
    e.err   = eerr;
    e.tout  = etout;
    exp_q.push_back(e);
    drive_req(addr, wr, wdata, strb);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk_i);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge pclk_i); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // Reset state
    #2;
    chk("reset outputs {psel,penable,rsp_valid,req_ready}",
        {60'd0, psel_o, penable_o, rsp_valid_o, req_ready_o}, 64'd0);
    chk("reset paddr/rdata", {paddr_o, rsp_rdata_o}, 64'd0);
    repeat (2) @(posedge pclk_i);
    #1 preset_ni = 1'b1;
    @(negedge pclk_i);
    @(negedge pclk_i);
    chk("req_ready after reset", {63'd0, req_ready_o}, 64'd1);

    // Basic read: one SETUP, one ACCESS
    do_req(BASE + 32'h8, 1'b0, 32'h0, 4'hF, 32'd2, 1'b0, 1'b0);
    wait_drain();
    chk("read setup/access cycles", {32'(setup_cnt), 32'(access_cnt)}, {32'd1, 32'd1});
    chk("read setup addr/write/strb", {27'd0, s_addr, s_write, s_strb}, {27'd0, BASE + 32'h8, 1'b0, 4'h0});

    // Out-of-range reads
    do_req(32'h0002_FFFC, 1'b0, 32'h0, 4'h0, 32'd0, 1'b1, 1'b0);
    do_req(32'h0003_0028, 1'b0, 32'h0, 4'h0, 32'd0, 1'b1, 1'b0);
    wait_drain();

    // Writes are rejected by the read-only completer; rdata forced 0
    do_req(BASE, 1'b1, 32'hDEAD, 4'hF, 32'd0, 1'b1, 1'b0);
    wait_drain();
    chk("write setup fields", {27'd0, s_write, s_strb, s_wdata}, {27'd0, 1'b1, 4'hF, 32'hDEAD});
    do_req(BASE + 32'h8, 1'b1, 32'h1234, 4'h3, 32'd0, 1'b1, 1'b0);
    do_req(BASE, 1'b0, 32'h0, 4'h0, 32'd0, 1'b0, 1'b0);
    do_req(BASE + 32'h1C, 1'b0, 32'h0, 4'h0, 32'd7, 1'b0, 1'b0);
    wait_drain();

    // Response backpressure with a queued request
    rsp_ready_i = 1'b0;
    do_req(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 32'd1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk_i);
      if (rsp_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rsp_valid seen", {63'd0, seen}, 64'd1);
    @(posedge pclk_i); #1;
    begin
      exp_t e;
      e.rdata = 32'd4;
      e.err   = 1'b0;
      e.tout  = 1'b0;
      exp_q.push_back(e);
    end
    req_addr_i  = BASE + 32'h10;
    req_write_i = 1'b0;
    req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk_i);
      chk("held rsp {valid,req_ready,rdata,err,tout}",
          {28'd0, rsp_valid_o, req_ready_o, rsp_rdata_o, rsp_err_o, rsp_tout_o},
          {28'd0, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0});
    end
    @(posedge pclk_i); #1 rsp_ready_i = 1'b1;
    @(negedge pclk_i);
    @(negedge pclk_i);
    chk("after rsp handshake {psel,req_ready}", {62'd0, psel_o, req_ready_o}, {62'd0, 1'b0, 1'b1});
    @(posedge pclk_i); #1 req_valid_i = 1'b0;
    @(negedge pclk_i);
    chk("queued req SETUP {psel,penable,paddr}", {30'd0, psel_o, penable_o, paddr_o},
        {30'd0, 1'b1, 1'b0, BASE + 32'h10});
    wait_drain();

    // Hung completer -> timeout after 16 ACCESS cycles
    hang = 1'b1;
    do_req(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 32'd0, 1'b1, 1'b1);
    wait_drain();
    chk("timeout access cycles", 64'(access_cnt), 64'd16);
    hang = 1'b0;

    // Ready on the 16th ACCESS cycle wins over timeout
    wait_states = 15;
    do_req(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 32'd2, 1'b0, 1'b0);
    wait_drain();
    chk("late-ready access cycles", 64'(access_cnt), 64'd16);
    wait_states = 0;

    // Reset during ACCESS
    hang = 1'b1;
    drive_req(BASE + 32'h8, 1'b0, 32'h0, 4'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk_i);
      if (penable_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reached ACCESS", {63'd0, seen}, 64'd1);
    #2 preset_ni = 1'b0;
    #1;
    chk("async reset {psel,penable,rsp_valid,req_ready}",
        {60'd0, psel_o, penable_o, rsp_valid_o, req_ready_o}, 64'd0);
    hang = 1'b0;
    @(posedge pclk_i); #1 preset_ni = 1'b1;
    do_req(BASE + 32'h24, 1'b0, 32'h0, 4'h0, 32'd9, 1'b0, 1'b0);
    wait_drain();
    chk("post-reset read setup/access", {32'(setup_cnt), 32'(access_cnt)}, {32'd1, 32'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
